// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage elastic (valid/ready) ALU pipeline.
//
// Stage 1 captures the request (operands, opcode, tag). The ALU result is
// computed combinationally from the stage-1 registers. Stage 2 registers the
// result, flags and tag, and drives the output interface. The pipeline holds
// at most two ops and never reorders them.
//
// Optional feature macro: ALU_SAT_EN
//   defined   : ADD saturates to all-ones on carry out, SUB saturates to zero
//               on borrow; carry/ovf still report the unsaturated arithmetic.
//   undefined : ADD/SUB wrap modulo 2^WIDTH.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   TAG_W  request tag width (>= 1)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_a, in_b           operands
//   in_op                000 ADD, 001 SUB, 010 GTU, 011 GTS,
//                        100 AND, 101 OR, 110 XOR, 111 SHL
//   in_tag               user tag, returned on out_tag
//   out_valid/out_ready  result handshake
//   out_result           result
//   out_carry            carry (ADD) / no-borrow (SUB)
//   out_zero             out_result == 0
//   out_ovf              signed overflow (ADD/SUB)
//   out_tag              tag of this result
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_GTU = 3'b010;
  localparam logic [2:0] OP_GTS = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // Handshake
  logic s2_load;
  logic in_accept;

  // ALU combinational outputs
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             arith_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_zero;

  // Stage 2 can take a new op when it is empty or is draining this cycle;
  // stage 1 can accept when it is empty or is moving into stage 2.
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign in_accept = in_valid && in_ready;

  // ALU datapath evaluated from the stage-1 registers.
  always_comb begin
    // SUB reuses the adder as a + ~b + 1; carry out then means "no borrow".
    b_eff     = (op_q == OP_SUB) ? ~b_q : b_q;
    sum       = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    arith_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    alu_res   = {WIDTH{1'b0}};
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
`ifdef ALU_SAT_EN
        alu_res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        alu_res = sum[WIDTH-1:0];
`endif
        alu_carry = sum[WIDTH];
        alu_ovf   = arith_ovf;
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        alu_res = sum[WIDTH] ? sum[WIDTH-1:0] : {WIDTH{1'b0}};
`else
        alu_res = sum[WIDTH-1:0];
`endif
        alu_carry = sum[WIDTH];
        alu_ovf   = arith_ovf;
      end
      OP_GTU:  alu_res = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
      OP_GTS:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  alu_res = a_q << b_q[SH_W-1:0];
      default: alu_res = {WIDTH{1'b0}};
    endcase
    // zero follows the final (possibly saturated) result
    alu_zero = (alu_res == {WIDTH{1'b0}});
  end

  // Next-state for stage 1: load on accept, otherwise hold.
  always_comb begin
    s1_valid_d = in_accept || (s1_valid_q && !s2_load);
    if (in_accept) begin
      a_d   = in_a;
      b_d   = in_b;
      op_d  = in_op;
      tag_d = in_tag;
    end else begin
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      tag_d = tag_q;
    end
  end

  // Next-state for stage 2: load the ALU result when stage 1 moves forward,
  // otherwise hold so outputs stay stable under backpressure.
  always_comb begin
    out_valid_d = s2_load || (out_valid_q && !out_ready);
    if (s2_load) begin
      res_d     = alu_res;
      carry_d   = alu_carry;
      zero_d    = alu_zero;
      ovf_d     = alu_ovf;
      out_tag_d = tag_q;
    end else begin
      res_d     = res_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      out_tag_d = out_tag_q;
    end
  end

  // Pipeline registers; reset discards any ops in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 3'b000;
      tag_q       <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_tag_q   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_ovf;
  logic [3:0]  out_tag;

  // second, 8-bit instance for the narrow shift case
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_a8;
  logic [7:0]  in_b8;
  logic [2:0]  in_op8;
  logic [3:0]  in_tag8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out_result8;
  logic        out_carry8;
  logic        out_zero8;
  logic        out_ovf8;
  logic [3:0]  out_tag8;

  int tests = 0;
  int fails = 0;
  vec_t pend[$];
  vec_t sb[$];
  logic last_acc;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_tag(out_tag)
  );

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .out_carry(out_carry8), .out_zero(out_zero8),
    .out_ovf(out_ovf8), .out_tag(out_tag8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tag, input logic [31:0] r, input logic c,
                              input logic z, input logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.r = r; v.c = c; v.z = z; v.o = o;
    return v;
  endfunction

  // reference model, written from the arithmetic definitions
  function automatic vec_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
    vec_t v;
    logic [32:0] t;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.c = 1'b0; v.o = 1'b0; v.r = 32'h0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        v.r = t[31:0]; v.c = t[32];
        v.o = (a[31] == b[31]) && (v.r[31] != a[31]);
`ifdef ALU_SAT_EN
        if (v.c) v.r = 32'hFFFF_FFFF;
`endif
      end
      3'd1: begin
        t = {1'b0, a} - {1'b0, b};
        v.r = t[31:0]; v.c = (a >= b);
        v.o = (a[31] != b[31]) && (v.r[31] != a[31]);
`ifdef ALU_SAT_EN
        if (!v.c) v.r = 32'h0;
`endif
      end
      3'd2: v.r = (a > b) ? 32'd1 : 32'd0;
      3'd3: v.r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      3'd4: v.r = a & b;
      3'd5: v.r = a | b;
      3'd6: v.r = a ^ b;
      default: v.r = a << b[4:0];
    endcase
    v.z = (v.r == 32'h0);
    return v;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] s [5];
    s[0] = 32'h0; s[1] = 32'h1; s[2] = 32'hFFFF_FFFF; s[3] = 32'h8000_0000; s[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 2) == 0) return s[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // one clock: drive at posedge+1, detect accept at negedge, settle +1
  // rmode: 0 = out_ready low, 1 = out_ready high, 2 = random
  task automatic run_cycle(input int rmode);
    @(posedge clk); #1;
    if (rmode == 0) out_ready = 1'b0;
    else if (rmode == 1) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 3) != 0);
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      in_a = pend[0].a; in_b = pend[0].b; in_op = pend[0].op; in_tag = pend[0].tag;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      sb.push_back(pend[0]);
      void'(pend.pop_front());
    end
    #1;
  endtask

  task automatic drain(input int rmode);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 400) begin
      run_cycle(rmode);
      n++;
    end
    check("drain_timeout", 64'(pend.size() + sb.size()), 64'd0);
  endtask

  // output monitor: scoreboard compare on transfer, stability under stall
  initial begin
    logic        prev_hold;
    logic [39:0] prev_out;
    vec_t        e;
    prev_hold = 1'b0;
    prev_out  = 40'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          check("hold_stable", {24'h0, out_valid, out_result, out_carry, out_zero, out_ovf, out_tag},
                {24'h0, prev_out});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_result", 64'(out_result), 64'(e.r));
            check("out_carry", 64'(out_carry), 64'(e.c));
            check("out_zero", 64'(out_zero), 64'(e.z));
            check("out_ovf", 64'(out_ovf), 64'(e.o));
            check("out_tag", 64'(out_tag), 64'(e.tag));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = {out_valid, out_result, out_carry, out_zero, out_ovf, out_tag};
      end
    end
  end

  initial begin
    vec_t tbl [15];
    logic acc_a [12];
    logic ov_a [12];
    int   acc_cnt;
    int   n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'h0; in_b = 32'h0; in_op = 3'd0; in_tag = 4'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_a8 = 8'h0; in_b8 = 8'h0; in_op8 = 3'd0; in_tag8 = 4'd0;
    last_acc = 1'b0;

    // expected values worked out by hand
`ifdef ALU_SAT_EN
    tbl[0]  = mk(3'd0, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(3'd1, 32'h0, 32'h1, 4'd2, 32'h0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(3'd0, 32'h8000_0000, 32'h8000_0000, 4'd12, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
`else
    tbl[0]  = mk(3'd0, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h0, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(3'd1, 32'h0, 32'h1, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(3'd0, 32'h8000_0000, 32'h8000_0000, 4'd12, 32'h0, 1'b1, 1'b1, 1'b1);
`endif
    tbl[1]  = mk(3'd1, 32'h8000_0000, 32'h1, 4'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    tbl[3]  = mk(3'd2, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(3'd3, 32'hFFFF_FFFF, 32'h1, 4'd4, 32'h0, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(3'd5, 32'h1234_0000, 32'h0000_5678, 4'd6, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd7, 32'h0, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(3'd7, 32'h0000_0081, 32'h0000_0029, 4'd8, 32'h0001_0200, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(3'd7, 32'h1, 32'h1F, 4'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(3'd0, 32'h7FFF_FFFF, 32'h1, 4'd10, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(3'd1, 32'h5, 32'h5, 4'd11, 32'h0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(3'd3, 32'h1, 32'hFFFF_FFFF, 4'd13, 32'h1, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(3'd2, 32'h1, 32'hFFFF_FFFF, 4'd14, 32'h0, 1'b0, 1'b1, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table, no backpressure
    for (int i = 0; i < 15; i++) pend.push_back(tbl[i]);
    drain(1);

    // same table under random backpressure
    for (int i = 0; i < 15; i++) pend.push_back(tbl[i]);
    drain(2);

    // random ops against the model, random backpressure
    for (int i = 0; i < 60; i++)
      pend.push_back(model(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 4'(i)));
    drain(2);

    // stall: 3 ops offered, output blocked for 6 cycles
    for (int i = 0; i < 3; i++)
      pend.push_back(model(3'd0, 32'(i * 16), 32'h1, 4'(i)));
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(0);
      if (last_acc) acc_cnt++;
    end
    check("stall_accepted", 64'(acc_cnt), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    drain(1);

    // 8 back-to-back ops at full throughput
    for (int i = 0; i < 8; i++)
      pend.push_back(model(3'd6, 32'(i * 7), 32'h55, 4'(i)));
    for (int k = 0; k < 12; k++) begin
      run_cycle(1);
      acc_a[k] = last_acc;
      ov_a[k]  = out_valid;
    end
    for (int k = 0; k < 8; k++) check("b2b_accept", 64'(acc_a[k]), 64'd1);
    check("b2b_ov0", 64'(ov_a[0]), 64'd0);
    check("b2b_ov1", 64'(ov_a[1]), 64'd0);
    for (int k = 2; k < 10; k++) check("b2b_ov_stream", 64'(ov_a[k]), 64'd1);
    drain(1);

    // async reset with both stages full
    pend.push_back(model(3'd0, 32'h10, 32'h20, 4'd5));
    pend.push_back(model(3'd1, 32'h30, 32'h20, 4'd6));
    for (int i = 0; i < 3; i++) run_cycle(0);
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    check("prerst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_result", 64'(out_result), 64'd0);
    sb.delete();
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1);
      check("postrst_no_stale", 64'(out_valid), 64'd0);
    end
    pend.push_back(model(3'd5, 32'hC000_0000, 32'h3, 4'd9));
    drain(1);

    // 8-bit SHL: shift amount uses only b[2:0]
    @(posedge clk); #1;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    in_a8 = 8'h81; in_b8 = 8'h09; in_op8 = 3'd7; in_tag8 = 4'd7;
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w8_timeout", 64'(out_valid8), 64'd1);
    check("w8_shl_result", 64'(out_result8), 64'h02);
    check("w8_shl_tag", 64'(out_tag8), 64'd7);
    check("w8_shl_zero", 64'(out_zero8), 64'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
